// File: rtl/iir_stimulus_gen_if.sv
// Stimulus generator port bundle: request fields in,
// filter sample stream and status out.
interface iir_stimulus_gen_if #(
  parameter int word_size  = 8,
  parameter int count_size = 16
);
  logic                  start;
  logic                  abort;
  logic [1:0]            mode;
  logic [word_size-1:0]  amplitude;
  logic [7:0]            half_period;
  logic [count_size-1:0] lead_cycles;
  logic [count_size-1:0] num_samples;
  logic [word_size-1:0]  Data_out;
  logic                  sample_valid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, mode, amplitude,
    output half_period, lead_cycles, num_samples,
    input  Data_out, sample_valid, busy, done
  );

  modport slave (
    input  start, abort, mode, amplitude,
    input  half_period, lead_cycles, num_samples,
    output Data_out, sample_valid, busy, done
  );
endinterface

// File: rtl/iir_stimulus_gen.sv
// Impulse/step/square/ramp sample source for the IIR/FIR
// filter Data_in port, with zero lead-in and done pulse.
module iir_stimulus_gen #(
  parameter int word_size  = 8,
  parameter int count_size = 16
) (
  input logic               clock,
  input logic               reset,
  iir_stimulus_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]            mode_q, mode_d;
  logic [word_size-1:0]  amp_q, amp_d;
  logic [7:0]            hp_q, hp_d;
  logic [count_size-1:0] num_q, num_d;
  logic [count_size-1:0] cnt_q, cnt_d;
  logic [word_size-1:0]  acc_q, acc_d;
  logic [7:0]            phase_q, phase_d;
  logic                  level_q, level_d;
  logic                  first_q, first_d;
  logic [word_size-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [7:0] hp_in_m1;
  logic [7:0] hp_q_m1;

  // A zero half period behaves like one: reload value 0.
  always_comb begin
    hp_in_m1 = (bus.half_period == 8'd0) ?
               8'd0 : bus.half_period - 8'd1;
    hp_q_m1  = (hp_q == 8'd0) ? 8'd0 : hp_q - 8'd1;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    amp_d   = amp_q;
    hp_d    = hp_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    phase_d = phase_q;
    level_d = level_q;
    first_d = first_q;
    data_d  = '0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          amp_d   = bus.amplitude;
          hp_d    = bus.half_period;
          num_d   = bus.num_samples;
          acc_d   = '0;
          phase_d = hp_in_m1;
          level_d = 1'b1;
          first_d = 1'b1;
          if (bus.lead_cycles != '0) begin
            cnt_d   = bus.lead_cycles;
            state_d = S_LEAD;
          end else if (bus.num_samples != '0) begin
            cnt_d   = bus.num_samples;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LEAD: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (cnt_q == count_size'(1)) begin
          cnt_d   = num_q;
          state_d = (num_q != '0) ? S_RUN : S_DONE;
        end else begin
          cnt_d = cnt_q - count_size'(1);
        end
      end
      S_RUN: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        unique case (mode_q)
          2'd0: data_d = first_q ? amp_q : '0;
          2'd1: data_d = amp_q;
          2'd2: data_d = level_q ? amp_q : '0;
          default: data_d = acc_q;
        endcase
        first_d = 1'b0;
        acc_d   = acc_q + amp_q;
        if (phase_q == 8'd0) begin
          phase_d = hp_q_m1;
          level_d = ~level_q;
        end else begin
          phase_d = phase_q - 8'd1;
        end
        if (cnt_q == count_size'(1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - count_size'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort) begin
      state_d = S_IDLE;
      data_d  = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      amp_q   <= '0;
      hp_q    <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      phase_q <= '0;
      level_q <= 1'b0;
      first_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      amp_q   <= amp_d;
      hp_q    <= hp_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      phase_q <= phase_d;
      level_q <= level_d;
      first_q <= first_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Data_out     = data_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_iir_stimulus_gen.sv
// Directed scoreboard bench for iir_stimulus_gen: expected
// per-cycle outputs are queued at start and popped each cycle.
module tb_iir_stimulus_gen;

  localparam int W = 8;
  localparam int C = 16;

  logic clock = 1'b0;
  logic reset;

  iir_stimulus_gen_if #(.word_size(W), .count_size(C)) bus ();

  iir_stimulus_gen #(.word_size(W), .count_size(C)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // {sample_valid, busy, done, Data_out}
  typedef logic [W+2:0] obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic obs_t pk(logic v, logic b, logic d,
                              logic [W-1:0] x);
    return {v, b, d, x};
  endfunction

  function automatic logic [W-1:0] model(int m, int a,
                                         int hp, int n);
    int h;
    h = (hp == 0) ? 1 : hp;
    case (m)
      0:       return (n == 0) ? W'(a) : '0;
      1:       return W'(a);
      2:       return (((n / h) % 2) == 0) ? W'(a) : '0;
      default: return W'(n * a);
    endcase
  endfunction

  task automatic check(string tag);
    obs_t e;
    obs_t o;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    o = {bus.sample_valid, bus.busy, bus.done, bus.Data_out};
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // kill: 0 none, 1 abort, 2 reset, applied after entry kill_at.
  // poke_at: cycle index at which a stray start is driven.
  task automatic play(string tag, int m, int a, int hp,
                      int lead, int num, int kill,
                      int kill_at, int poke_at);
    int n;
    bus.mode        = 2'(m);
    bus.amplitude   = W'(a);
    bus.half_period = 8'(hp);
    bus.lead_cycles = C'(lead);
    bus.num_samples = C'(num);
    bus.start       = 1'b1;
    exp_q.push_back(pk(0, 0, 0, '0));
    for (int i = 0; i < lead; i++)
      exp_q.push_back(pk(1, 1, 0, '0));
    for (int i = 0; i < num; i++)
      exp_q.push_back(pk(1, 1, 0, model(m, a, hp, i)));
    exp_q.push_back(pk(0, 0, 1, '0));
    exp_q.push_back(pk(0, 0, 0, '0));
    if (kill != 0) begin
      while (exp_q.size() > kill_at + 1)
        void'(exp_q.pop_back());
      exp_q.push_back(pk(0, 0, 0, '0));
      exp_q.push_back(pk(0, 0, 0, '0));
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      reset           = 1'b0;
      bus.mode        = 2'($urandom);
      bus.amplitude   = W'($urandom);
      bus.half_period = 8'($urandom);
      bus.lead_cycles = C'($urandom);
      bus.num_samples = C'($urandom);
      if (i == poke_at) bus.start = 1'b1;
      @(negedge clock);
      check(tag);
      if (kill == 1 && i == kill_at) bus.abort = 1'b1;
      if (kill == 2 && i == kill_at) reset = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.mode        = '0;
    bus.amplitude   = '0;
    bus.half_period = '0;
    bus.lead_cycles = '0;
    bus.num_samples = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    exp_q.push_back(pk(0, 0, 0, '0));
    check("reset");
    reset = 1'b0;

    play("impulse", 0, 1, 0, 9, 20, 0, 0, -1);
    play("step", 1, 'hFF, 0, 0, 5, 0, 0, -1);
    play("square_hp3", 2, 'h40, 3, 0, 10, 0, 0, -1);
    play("square_hp0", 2, 'h40, 0, 2, 7, 0, 0, -1);
    play("ramp_poke", 3, 'h60, 0, 0, 6, 0, 0, 3);
    play("abort_step", 1, 'h33, 0, 0, 20, 1, 4, -1);
    play("after_abort", 3, 'h07, 0, 1, 4, 0, 0, -1);
    play("reset_step", 1, 'h33, 0, 0, 20, 2, 4, -1);
    play("after_reset", 0, 'h5A, 0, 2, 3, 0, 0, -1);
    play("zero_len", 1, 'h11, 0, 0, 0, 0, 0, 0);
    play("lead_only", 1, 'h22, 0, 3, 0, 0, 0, -1);

    // start together with abort in IDLE must not launch
    bus.mode        = 2'd1;
    bus.amplitude   = W'(8'h77);
    bus.lead_cycles = '0;
    bus.num_samples = C'(4);
    bus.start       = 1'b1;
    bus.abort       = 1'b1;
    exp_q.push_back(pk(0, 0, 0, '0));
    exp_q.push_back(pk(0, 0, 0, '0));
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clock);
    check("abort_start_a");
    @(posedge clock);
    @(negedge clock);
    check("abort_start_b");

    play("final_step", 1, 'h81, 0, 1, 2, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/iir_stimulus_gen.md
Name: iir_stimulus_gen

Overview:
Synthesizable stimulus source that drives the sample input of the IIR/FIR filter blocks. It plays impulse, step, square and ramp sequences into the filter's Data_in port, one sample per clock. It replaces hand-timed bench stimulus and also serves as an on-chip built-in self-test source. Each sequence has a programmable zero lead-in, amplitude and length, and the block signals completion.

Parameters:
word_size, 8, sample width; matches the filter's word_size_in.
count_size, 16, width of the lead-in and sample-count fields.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a sequence; accepted only in IDLE.
abort  input  1  terminates any sequence; wins over everything except reset.
mode  input  2  sequence type: 0 impulse, 1 step, 2 square, 3 ramp.
amplitude  input  word_size  pulse/step level, or ramp increment.
half_period  input  8  square-wave half period in samples; 0 is treated as 1.
lead_cycles  input  count_size  number of zero samples before the sequence.
num_samples  input  count_size  number of sequence samples after the lead-in.
Data_out  output  word_size  sample to the filter's Data_in.
sample_valid  output  1  high while Data_out carries a sequence sample (lead-in or run).
busy  output  1  high in LEAD and RUN.
done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset: state IDLE; Data_out=0, sample_valid=0, busy=0, done=0; all counters and latched fields cleared.
- All outputs are registered.
- FSM states: IDLE, LEAD, RUN, DONE.
- IDLE:
  - Data_out=0.
  - When start=1, latch mode, amplitude, half_period, lead_cycles and num_samples. Later input changes are ignored until the next start.
  - Next state is LEAD if lead_cycles>0, else RUN if num_samples>0, else DONE.
- LEAD:
  - Data_out=0, sample_valid=1.
  - Runs for exactly lead_cycles cycles, then goes to RUN, or to DONE if num_samples=0.
- RUN: runs exactly num_samples cycles, sample_valid=1. With n = sample index from 0:
  - impulse: Data_out=amplitude at n=0, else 0.
  - step: Data_out=amplitude for all n.
  - square: amplitude for the first half_period samples, 0 for the next half_period, and so on. It always starts high.
  - ramp: Data_out=n*amplitude mod 2^word_size. It starts at 0 and wraps silently on overflow.
- DONE:
  - Lasts one cycle: done=1, Data_out=0, sample_valid=0, busy=0.
  - Next state is IDLE.
  - A start in this cycle is ignored.
- Latency: start accepted on edge k means the first lead-in or run sample appears on Data_out after edge k+1, with sample_valid=1.
- Total valid samples = lead_cycles + num_samples. done is asserted in the cycle after the last valid sample.
- start while busy: ignored, with no effect on the counters.
- abort in any state: next edge gives IDLE, Data_out=0, sample_valid=0, busy=0, and no done pulse. Abort and start together in IDLE: abort wins.
- reset mid-sequence: same outputs as abort, and the latched fields are cleared as well.
- Counters use count_size bits. The maximum sequence is 2^count_size-1 lead-in plus 2^count_size-1 run samples, with no wrap-around inside a sequence.
- Square-wave phase counter: reloads at half_period-1 and toggles the level on reaching 0.

Test Plan:
- Reset, then start with mode=0, amplitude=1, lead_cycles=9, num_samples=20 -> 9 zeros, then a single 1, then 19 zeros; sample_valid high for 29 cycles; done pulses once. This matches the filter's impulse-response setup.
- mode=1, amplitude=8'hFF, lead_cycles=0, num_samples=5 -> Data_out=FF for 5 cycles starting one cycle after start; done in the 6th cycle.
- mode=2, amplitude=8'h40, half_period=3, num_samples=10 -> 40,40,40,0,0,0,40,40,40,0. With half_period=0 -> alternates every sample: 40,0,40,0,...
- mode=3, amplitude=8'h60, num_samples=6 -> 00,60,C0,20,80,E0 (wraps); start pulsed mid-run has no effect.
- Abort at the 4th run sample of a 20-sample step -> next cycle Data_out=0, busy=0, no done pulse. A new start then runs normally. Repeat using reset instead of abort -> same outputs.
- lead_cycles=0, num_samples=0 -> IDLE→DONE, done pulses on the second edge after start, sample_valid never asserted.
